pkt_inject_arbiter: RTL and testbench
=====================================

# pkt_inject_arbiter

Packet-level round-robin arbiter that merges up to N_SRC flit generators onto the single local injection port of a mesh router. Once a source wins with a head flit, it owns the port until its tail flit is accepted, so packets are never interleaved. The block has one registered output stage, flags malformed traffic, and keeps packet and drop counters for traffic experiments.

## Interface
- N_SRC, 4: number of flit sources (2..8).
- FLIT_W, 32: flit width; the type field is always bits [FLIT_W-1:FLIT_W-2].
- CNT_W, 16: width of the statistics counters.
- clk  in  1  single clock; everything is on the rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk).
- src_flit  in  N_SRC*FLIT_W  flits, packed; source i occupies [i*FLIT_W +: FLIT_W].
- src_valid  in  N_SRC  per-source flit valid.
- src_ready  out  N_SRC  per-source accept (combinational).
- out_flit  out  FLIT_W  registered flit to the router local port.
- out_valid  out  1  out_flit valid.
- out_ready  in  1  router accepts out_flit.
- err_drop  out  1  one-cycle pulse: a flit was dropped.
- err_proto  out  1  one-cycle pulse: head flit arrived from the owner while locked.
- pkt_count  out  CNT_W  tails forwarded; wraps.
- drop_count  out  CNT_W  flits dropped; saturates at all-ones.

## Operation
- Flit type field: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 reserved.
- A transfer occurs on a source when src_valid[i] && src_ready[i] in the same cycle. At the output, a transfer occurs when out_valid && out_ready.
- slot_free = !out_valid || out_ready. When slot_free is 0, all src_ready are 0.
- IDLE state:
  - A source is eligible if it is valid and its flit type is head.
  - The rr_arbiter picks the first eligible source at or after rr_ptr, in increasing index order, wrapping.
  - If slot_free, the winner gets src_ready=1.
  - On that transfer, state becomes LOCKED and owner is set to the winner.
- Drop rule in IDLE: if no source is eligible and the lowest-index valid source holds a body, tail or reserved flit, that source gets src_ready=1 regardless of slot_free. The flit is consumed, not forwarded, err_drop pulses and drop_count increments. At most one drop per cycle.
- LOCKED state:
  - Only the owner gets src_ready, and only when slot_free.
  - Body flits are forwarded.
  - A tail flit is forwarded, then state becomes IDLE, rr_ptr becomes (owner+1) mod N_SRC, and pkt_count increments.
  - A head flit from the owner is forwarded, err_proto pulses, and the lock is kept.
  - A reserved flit from the owner is dropped (err_drop pulses, drop_count increments) and the lock is kept.
  - Non-owners are always stalled, never dropped.
- Single-flit packets are not supported. A head is always followed by at least a tail.

## Timing
- Source-to-output latency is 1 cycle: a flit accepted in cycle t appears on out_flit with out_valid=1 at t+1.
- Full throughput: one flit per cycle while out_ready=1.
- Under backpressure, out_flit and out_valid hold stable until an output transfer.
- Switching between sources costs no dead cycles: the tail of source A at t and the head of source B at t+1 are legal.
- Simultaneous output transfer and new source transfer in the same cycle: out_flit is replaced with no bubble.
- Reset (reset=0 at a clock edge):
  - Outputs: out_valid=0, out_flit=0, err_drop=0, err_proto=0, pkt_count=0, drop_count=0.
  - State: IDLE, owner=0, rr_ptr=0.
  - src_ready is forced to 0 while reset=0.
- Reset mid-packet discards the partial packet. The router side is responsible for recovery.
- rr_ptr wraps from N_SRC-1 to 0. pkt_count wraps to 0. drop_count saturates.

## Structure
- Shared package noc_flit_pkg holds:
  - Type constants FLIT_HEAD=2'b01, FLIT_BODY=2'b00, FLIT_TAIL=2'b10, FLIT_RSVD=2'b11.
  - FLIT_W.
  - Head field offsets: [29:16] timestamp, [15:12] destx, [11:8] desty, [7:0] pid.
- Sub-module rr_arbiter (parameter N; inputs req, ptr; output one-hot gnt; purely combinational). It is reused later by the router switch allocator.
- Top level contains the two-state FSM, the owner and rr_ptr registers, the output register and the counters.

## Test plan
- Single packet: src0 sends head 32'h4000_1105, body 32'h0000_0ABC, body 32'h0000_0DEF, tail 32'h8001_1234 back to back, with out_ready=1. Expected: the same four flits appear on out cycles 1-4, pkt_count=1, rr_ptr=1.
- Contention: src0 and src2 present heads in the same cycle with rr_ptr=0. Expected: the full src0 packet goes out, src2 is stalled (src_ready[2]=0) throughout, and the src2 head is accepted in the cycle after the src0 tail, with no interleaving.
- Backpressure: out_ready=0 for 3 cycles after a body flit. Expected: out_flit is held unchanged, all src_ready=0, and no flit is lost or duplicated after release.
- Drop: src1 presents body 32'h0000_00AA in IDLE. Expected: src_ready[1]=1, err_drop pulses for 1 cycle, drop_count=1, out_valid stays 0.
- Reset mid-packet: reset=0 for 1 cycle after the head and one body. Expected: out_valid=0 and IDLE next cycle; afterwards a src3 head is accepted and forwarded normally.
- Fairness: all four sources stream 2-flit packets continuously. Expected: grant order 0,1,2,3,0,…; after 8 packets, pkt_count=8 with each source served twice.

Source files
------------

// File: rtl/noc_flit_pkg.sv
// Shared flit definitions for the NoC injection path and router.
package noc_flit_pkg;

   // Default flit width; the type field always sits in the top two bits.
   localparam int unsigned FLIT_W = 32;

   // Flit type field encodings.
   localparam logic [1:0] FLIT_HEAD = 2'b01;
   localparam logic [1:0] FLIT_BODY = 2'b00;
   localparam logic [1:0] FLIT_TAIL = 2'b10;
   localparam logic [1:0] FLIT_RSVD = 2'b11;

   // Head flit field offsets.
   localparam int unsigned HEAD_TS_HI    = 29;
   localparam int unsigned HEAD_TS_LO    = 16;
   localparam int unsigned HEAD_DESTX_HI = 15;
   localparam int unsigned HEAD_DESTX_LO = 12;
   localparam int unsigned HEAD_DESTY_HI = 11;
   localparam int unsigned HEAD_DESTY_LO = 8;
   localparam int unsigned HEAD_PID_HI   = 7;
   localparam int unsigned HEAD_PID_LO   = 0;

   // Injection arbiter packet-ownership state.
   typedef enum logic [0:0] {
      StIdle,
      StLocked
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or
// after ptr, scanning upward in index order and wrapping.
module rr_arbiter #(
   parameter  int unsigned N     = 4,
   localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt
);

   logic             found;
   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] idx;

   // Walk the N candidate positions starting at ptr; the first requester wins.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < int'(N); k++) begin
         sum = {1'b0, ptr} + (PTR_W + 1)'(k);
         if (sum >= (PTR_W + 1)'(N)) begin
            sum = sum - (PTR_W + 1)'(N);
         end
         idx = sum[PTR_W-1:0];
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pkt_inject_arbiter.sv
// Packet-level round-robin merge of N_SRC flit sources onto one router local
// port. A source that wins with a head keeps the port until its tail is taken.
// One registered output stage; malformed traffic is flagged and counted.
module pkt_inject_arbiter #(
   parameter int unsigned N_SRC  = 4,
   parameter int unsigned FLIT_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_SRC*FLIT_W-1:0] src_flit,
   input  logic [N_SRC-1:0]        src_valid,
   output logic [N_SRC-1:0]        src_ready,
   output logic [FLIT_W-1:0]       out_flit,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    err_drop,
   output logic                    err_proto,
   output logic [CNT_W-1:0]        pkt_count,
   output logic [CNT_W-1:0]        drop_count
);

   import noc_flit_pkg::*;

   localparam int unsigned      IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SRC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   // Registered state.
   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [FLIT_W-1:0] out_flit_q, out_flit_d;
   logic              out_valid_q, out_valid_d;
   logic              err_drop_q, err_drop_d;
   logic              err_proto_q, err_proto_d;
   logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
   logic [CNT_W-1:0]  drop_count_q, drop_count_d;

   // Per-source decode.
   logic [FLIT_W-1:0] flit_arr [N_SRC];
   logic [1:0]        ftype    [N_SRC];
   logic [N_SRC-1:0]  head_req;
   logic [N_SRC-1:0]  gnt;

   // Selection and per-cycle events.
   logic              slot_free;
   logic              win_any;
   logic              drop_any;
   logic [IDX_W-1:0]  win_idx;
   logic [IDX_W-1:0]  drop_idx;
   logic [IDX_W-1:0]  sel_idx;
   logic [FLIT_W-1:0] sel_flit;
   logic [1:0]        sel_type;
   logic              fwd;
   logic              drop;
   logic              proto;
   logic              tail_done;

   // The output register can take a new flit when empty or being drained.
   assign slot_free = !out_valid_q || out_ready;

   // Unpack source flits and mark sources presenting a head.
   always_comb begin
      for (int i = 0; i < int'(N_SRC); i++) begin
         flit_arr[i] = src_flit[i*FLIT_W +: FLIT_W];
         ftype[i]    = flit_arr[i][FLIT_W-1 -: 2];
         head_req[i] = src_valid[i] && (ftype[i] == FLIT_HEAD);
      end
   end

   rr_arbiter #(
      .N (N_SRC)
   ) u_rr_arbiter (
      .req (head_req),
      .ptr (rr_ptr_q),
      .gnt (gnt)
   );

   assign win_any = |head_req;

   // Encode the one-hot grant and find the lowest-index valid source.
   always_comb begin
      win_idx  = '0;
      drop_idx = '0;
      drop_any = 1'b0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (gnt[i]) begin
            win_idx = IDX_W'(i);
         end
      end
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (src_valid[i]) begin
            drop_idx = IDX_W'(i);
            drop_any = 1'b1;
         end
      end
   end

   // Source whose flit is considered this cycle.
   always_comb begin
      if (state_q == StLocked) begin
         sel_idx = owner_q;
      end else if (win_any) begin
         sel_idx = win_idx;
      end else begin
         sel_idx = drop_idx;
      end
      sel_flit = flit_arr[sel_idx];
      sel_type = sel_flit[FLIT_W-1 -: 2];
   end

   // Ownership FSM: grants, drops and lock release.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      src_ready = '0;
      fwd       = 1'b0;
      drop      = 1'b0;
      proto     = 1'b0;
      tail_done = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (win_any) begin
               if (slot_free) begin
                  src_ready = gnt;
                  fwd       = 1'b1;
                  state_d   = StLocked;
                  owner_d   = win_idx;
               end
            end else if (drop_any) begin
               // Stray non-head flit: consume it even when the output is blocked.
               src_ready[drop_idx] = 1'b1;
               drop                = 1'b1;
            end
         end
         StLocked: begin
            if (slot_free) begin
               src_ready[owner_q] = 1'b1;
               if (src_valid[owner_q]) begin
                  case (sel_type)
                     FLIT_BODY: begin
                        fwd = 1'b1;
                     end
                     FLIT_TAIL: begin
                        fwd       = 1'b1;
                        tail_done = 1'b1;
                        state_d   = StIdle;
                        rr_ptr_d  = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                     end
                     FLIT_HEAD: begin
                        // Owner restarted a packet: pass it on but flag it.
                        fwd   = 1'b1;
                        proto = 1'b1;
                     end
                     default: begin
                        drop = 1'b1;
                     end
                  endcase
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (!reset) begin
         src_ready = '0;
      end
   end

   // Output stage, error pulses and statistics next state.
   always_comb begin
      out_flit_d   = out_flit_q;
      out_valid_d  = out_valid_q;
      pkt_count_d  = pkt_count_q;
      drop_count_d = drop_count_q;
      err_drop_d   = drop;
      err_proto_d  = proto;

      if (fwd) begin
         out_flit_d  = sel_flit;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (tail_done) begin
         pkt_count_d = pkt_count_q + 1'b1;
      end
      if (drop && (drop_count_q != CNT_MAX)) begin
         drop_count_d = drop_count_q + 1'b1;
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         owner_q      <= '0;
         rr_ptr_q     <= '0;
         out_flit_q   <= '0;
         out_valid_q  <= 1'b0;
         err_drop_q   <= 1'b0;
         err_proto_q  <= 1'b0;
         pkt_count_q  <= '0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         out_flit_q   <= out_flit_d;
         out_valid_q  <= out_valid_d;
         err_drop_q   <= err_drop_d;
         err_proto_q  <= err_proto_d;
         pkt_count_q  <= pkt_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign out_flit   = out_flit_q;
   assign out_valid  = out_valid_q;
   assign err_drop   = err_drop_q;
   assign err_proto  = err_proto_q;
   assign pkt_count  = pkt_count_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_pkt_inject_arbiter.sv
// Self-checking bench for pkt_inject_arbiter with a cycle-level reference model.
module tb_pkt_inject_arbiter;
   import noc_flit_pkg::*;

   localparam int N  = 4;
   localparam int FW = 32;
   localparam int CW = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [N*FW-1:0] src_flit;
   logic [N-1:0]    src_valid;
   logic [N-1:0]    src_ready;
   logic [FW-1:0]   out_flit;
   logic            out_valid;
   logic            out_ready;
   logic            err_drop;
   logic            err_proto;
   logic [CW-1:0]   pkt_count;
   logic [CW-1:0]   drop_count;

   pkt_inject_arbiter #(
      .N_SRC  (N),
      .FLIT_W (FW),
      .CNT_W  (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .src_flit   (src_flit),
      .src_valid  (src_valid),
      .src_ready  (src_ready),
      .out_flit   (out_flit),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .err_drop   (err_drop),
      .err_proto  (err_proto),
      .pkt_count  (pkt_count),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Per-source flit queues; the source presents its front flit.
   logic [FW-1:0] q [N][$];
   bit            or_q[$];
   bit            rand_valid = 1'b0;
   bit            rand_ready = 1'b0;
   int            cyc = 0;

   // Observation logs.
   logic [FW-1:0] out_log[$];
   int            grant_log[$];
   int            acc_cyc[$];
   int            acc_src[$];
   logic [FW-1:0] acc_flit[$];
   int            err_drop_seen;

   // Reference model state.
   bit            m_init = 1'b0;
   bit            m_locked;
   int            m_owner;
   int            m_ptr;
   bit            m_ov;
   logic [FW-1:0] m_of;
   bit            m_ed;
   bit            m_ep;
   int            m_pkt;
   int            m_drop;

   function automatic logic [FW-1:0] mk(input logic [1:0] t);
      logic [29:0] p;
      p = 30'($urandom);
      return {t, p};
   endfunction

   function automatic int total_q();
      int s = 0;
      for (int i = 0; i < N; i++) s += q[i].size();
      return s;
   endfunction

   task automatic clear_all();
      for (int i = 0; i < N; i++) q[i].delete();
      or_q.delete();
      out_log.delete();
      grant_log.delete();
      acc_cyc.delete();
      acc_src.delete();
      acc_flit.delete();
      err_drop_seen = 0;
      rand_valid = 1'b0;
      rand_ready = 1'b0;
   endtask

   // One clock cycle: drive, check against the model, advance the model.
   task automatic step(input bit rst_val);
      logic [N-1:0]  exp_ready;
      logic [1:0]    t;
      logic [FW-1:0] fl;
      bit            slot_free, fwd, drp, prt;
      int            w, dv, src_acc;

      reset = rst_val;
      for (int i = 0; i < N; i++) begin
         if (q[i].size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
            src_valid[i] = 1'b1;
            src_flit[i*FW +: FW] = q[i][0];
         end else begin
            src_valid[i] = 1'b0;
            src_flit[i*FW +: FW] = $urandom;
         end
      end
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      else if (or_q.size() > 0) out_ready = or_q.pop_front();
      else out_ready = 1'b1;

      @(negedge clk);
      exp_ready = '0;
      fwd = 1'b0; drp = 1'b0; prt = 1'b0; src_acc = -1;
      slot_free = !m_ov || out_ready;
      if (rst_val && m_init) begin
         if (!m_locked) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
               int j;
               j = (m_ptr + k) % N;
               if (w < 0 && src_valid[j] && src_flit[j*FW+FW-2 +: 2] == FLIT_HEAD) w = j;
            end
            if (w >= 0) begin
               if (slot_free) begin
                  exp_ready[w] = 1'b1; fwd = 1'b1; src_acc = w;
               end
            end else begin
               dv = -1;
               for (int j = N - 1; j >= 0; j--) if (src_valid[j]) dv = j;
               if (dv >= 0) begin
                  exp_ready[dv] = 1'b1; drp = 1'b1; src_acc = dv;
               end
            end
         end else if (slot_free) begin
            exp_ready[m_owner] = 1'b1;
            if (src_valid[m_owner]) begin
               src_acc = m_owner;
               t = src_flit[m_owner*FW+FW-2 +: 2];
               if (t == FLIT_RSVD) drp = 1'b1;
               else fwd = 1'b1;
               if (t == FLIT_HEAD) prt = 1'b1;
            end
         end
      end

      checks++;
      if (src_ready !== exp_ready) begin
         failures++;
         $display("FAIL src_ready cyc=%0d got=%b exp=%b", cyc, src_ready, exp_ready);
      end
      if (m_init) begin
         checks++;
         if (out_valid !== m_ov) begin
            failures++;
            $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_ov);
         end
         checks++;
         if (out_flit !== m_of) begin
            failures++;
            $display("FAIL out_flit cyc=%0d got=%h exp=%h", cyc, out_flit, m_of);
         end
         checks++;
         if (err_drop !== m_ed || err_proto !== m_ep) begin
            failures++;
            $display("FAIL err_pulses cyc=%0d got=%b%b exp=%b%b", cyc, err_drop, err_proto,
                     m_ed, m_ep);
         end
         checks++;
         if (pkt_count !== CW'(m_pkt) || drop_count !== CW'(m_drop)) begin
            failures++;
            $display("FAIL counters cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, pkt_count,
                     drop_count, m_pkt, m_drop);
         end
         if (err_drop === 1'b1) err_drop_seen++;
      end
      if (out_valid === 1'b1 && out_ready) out_log.push_back(out_flit);

      @(posedge clk);
      #1;
      if (!rst_val) begin
         m_init = 1'b1; m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_ov = 1'b0; m_of = '0;
         m_ed = 1'b0; m_ep = 1'b0; m_pkt = 0; m_drop = 0;
      end else begin
         fl = '0;
         if (src_acc >= 0) begin
            fl = q[src_acc].pop_front();
            acc_cyc.push_back(cyc);
            acc_src.push_back(src_acc);
            acc_flit.push_back(fl);
            t = fl[FW-1 -: 2];
            if (!m_locked && fwd) begin
               m_locked = 1'b1; m_owner = src_acc; grant_log.push_back(src_acc);
            end else if (m_locked && t == FLIT_TAIL) begin
               m_locked = 1'b0; m_ptr = (m_owner + 1) % N; m_pkt = (m_pkt + 1) % (1 << CW);
            end
         end
         if (fwd) begin
            m_ov = 1'b1; m_of = fl;
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
         m_ed = drp;
         m_ep = prt;
         if (drp && m_drop < (1 << CW) - 1) m_drop++;
      end
      cyc++;
   endtask

   task automatic do_reset();
      clear_all();
      step(1'b0);
   endtask

   task automatic test_reset();
      clear_all();
      reset = 1'b0;
      src_valid = '1;
      for (int i = 0; i < N; i++) src_flit[i*FW +: FW] = {FLIT_HEAD, 30'(i)};
      out_ready = 1'b1;
      #1;
      checks++;
      if (src_ready !== '0) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=0", src_ready);
      end
      step(1'b0);
      step(1'b0);
      checks++;
      if (out_valid !== 1'b0 || out_flit !== '0 || err_drop !== 1'b0 || err_proto !== 1'b0 ||
          pkt_count !== '0 || drop_count !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%b %h %b %b %0d %0d exp=0 all", out_valid, out_flit,
                  err_drop, err_proto, pkt_count, drop_count);
      end
   endtask

   task automatic test_single_packet();
      logic [FW-1:0] exp[4];
      exp = '{32'h4000_1105, 32'h0000_0ABC, 32'h0000_0DEF, 32'h8001_1234};
      do_reset();
      for (int i = 0; i < 4; i++) q[0].push_back(exp[i]);
      repeat (6) step(1'b1);
      checks++;
      if (out_log.size() != 4) begin
         failures++;
         $display("FAIL single_count got=%0d exp=4", out_log.size());
      end
      for (int i = 0; i < 4 && i < out_log.size(); i++) begin
         checks++;
         if (out_log[i] !== exp[i]) begin
            failures++;
            $display("FAIL single_flit%0d got=%h exp=%h", i, out_log[i], exp[i]);
         end
      end
      checks++;
      if (pkt_count !== 16'd1 || dut.rr_ptr_q !== 2'd1) begin
         failures++;
         $display("FAIL single_state got=pkt%0d ptr%0d exp=pkt1 ptr1", pkt_count, dut.rr_ptr_q);
      end
   endtask

   task automatic test_contention();
      logic [FW-1:0] exp[5];
      int            t0, h2;
      exp = '{32'h4000_2201, 32'h0000_0111, 32'h8000_0222, 32'h4000_3302, 32'h8000_0333};
      do_reset();
      for (int i = 0; i < 3; i++) q[0].push_back(exp[i]);
      for (int i = 3; i < 5; i++) q[2].push_back(exp[i]);
      repeat (7) step(1'b1);
      checks++;
      if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 2) begin
         failures++;
         $display("FAIL contention_order got=%p exp=0,2", grant_log);
      end
      t0 = -100; h2 = -1;
      for (int i = 0; i < acc_src.size(); i++) begin
         if (acc_src[i] == 0 && acc_flit[i] == exp[2]) t0 = acc_cyc[i];
         if (acc_src[i] == 2 && acc_flit[i] == exp[3]) h2 = acc_cyc[i];
      end
      checks++;
      if (h2 != t0 + 1) begin
         failures++;
         $display("FAIL contention_switch got=%0d exp=%0d", h2, t0 + 1);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_log.size() <= i || out_log[i] !== exp[i]) begin
            failures++;
            $display("FAIL contention_flit%0d exp=%h", i, exp[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [FW-1:0] exp[4];
      exp = '{32'h4000_0a0a, 32'h0000_0001, 32'h0000_0002, 32'h8000_0003};
      do_reset();
      for (int i = 0; i < 4; i++) q[0].push_back(exp[i]);
      or_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      repeat (10) step(1'b1);
      checks++;
      if (out_log.size() != 4) begin
         failures++;
         $display("FAIL bp_count got=%0d exp=4", out_log.size());
      end
      for (int i = 0; i < 4 && i < out_log.size(); i++) begin
         checks++;
         if (out_log[i] !== exp[i]) begin
            failures++;
            $display("FAIL bp_flit%0d got=%h exp=%h", i, out_log[i], exp[i]);
         end
      end
   endtask

   task automatic test_drop();
      do_reset();
      q[1].push_back(32'h0000_00AA);
      repeat (4) step(1'b1);
      checks++;
      if (drop_count !== 16'd1 || err_drop_seen != 1 || out_log.size() != 0) begin
         failures++;
         $display("FAIL drop got=cnt%0d pulses%0d outs%0d exp=1,1,0", drop_count,
                  err_drop_seen, out_log.size());
      end
      checks++;
      if (acc_src.size() != 1 || acc_src[0] != 1) begin
         failures++;
         $display("FAIL drop_src got=%p exp=1", acc_src);
      end
   endtask

   task automatic test_reset_mid_packet();
      logic [FW-1:0] h3, t3;
      h3 = 32'h4000_3303;
      t3 = 32'h8000_3333;
      do_reset();
      q[0] = '{32'h4000_0001, 32'h0000_0011, 32'h0000_0022, 32'h8000_0033};
      step(1'b1);
      step(1'b1);
      q[0].delete();
      step(1'b0);
      checks++;
      if (out_valid !== 1'b0 || dut.state_q !== StIdle) begin
         failures++;
         $display("FAIL mid_reset got=ov%b st%0d exp=ov0 idle", out_valid, dut.state_q);
      end
      out_log.delete();
      grant_log.delete();
      q[3].push_back(h3);
      q[3].push_back(t3);
      repeat (5) step(1'b1);
      checks++;
      if (out_log.size() != 2 || out_log[0] !== h3 || out_log[1] !== t3) begin
         failures++;
         $display("FAIL mid_after got=%p exp=%h,%h", out_log, h3, t3);
      end
   endtask

   task automatic test_fairness();
      int served[N];
      do_reset();
      for (int i = 0; i < N; i++) begin
         served[i] = 0;
         repeat (2) begin
            q[i].push_back(mk(FLIT_HEAD));
            q[i].push_back(mk(FLIT_TAIL));
         end
      end
      repeat (18) step(1'b1);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (grant_log.size() <= i || grant_log[i] != i % N) begin
            failures++;
            $display("FAIL fair_grant%0d got=%p exp=%0d", i, grant_log, i % N);
         end
      end
      foreach (grant_log[i]) served[grant_log[i]]++;
      checks++;
      if (pkt_count !== 16'd8 || served[0] != 2 || served[1] != 2 || served[2] != 2 ||
          served[3] != 2) begin
         failures++;
         $display("FAIL fair_total got=%0d %p exp=8 each 2", pkt_count, served);
      end
   endtask

   task automatic test_random();
      int exp_fwd = 0, exp_drop = 0, exp_pkt = 0, budget = 0, r;
      do_reset();
      for (int s = 0; s < N; s++) begin
         repeat (5) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin q[s].push_back(mk(FLIT_BODY)); exp_drop++; end
            if (r == 1) begin q[s].push_back(mk(FLIT_RSVD)); exp_drop++; end
            if (r == 2) begin q[s].push_back(mk(FLIT_TAIL)); exp_drop++; end
            q[s].push_back(mk(FLIT_HEAD));
            exp_fwd++;
            repeat ($urandom_range(0, 3)) begin
               r = $urandom_range(0, 9);
               if (r == 0) begin q[s].push_back(mk(FLIT_RSVD)); exp_drop++; end
               else if (r == 1) begin q[s].push_back(mk(FLIT_HEAD)); exp_fwd++; end
               else begin q[s].push_back(mk(FLIT_BODY)); exp_fwd++; end
            end
            q[s].push_back(mk(FLIT_TAIL));
            exp_fwd++;
            exp_pkt++;
         end
      end
      rand_valid = 1'b1;
      rand_ready = 1'b1;
      while (total_q() > 0 && budget < 4000) begin
         step(1'b1);
         budget++;
      end
      checks++;
      if (budget >= 4000) begin
         failures++;
         $display("FAIL random_drain got=%0d left exp=0", total_q());
      end
      rand_ready = 1'b0;
      repeat (3) step(1'b1);
      checks++;
      if (out_log.size() != exp_fwd || pkt_count !== CW'(exp_pkt) ||
          drop_count !== CW'(exp_drop)) begin
         failures++;
         $display("FAIL random_totals got=%0d/%0d/%0d exp=%0d/%0d/%0d", out_log.size(),
                  pkt_count, drop_count, exp_fwd, exp_pkt, exp_drop);
      end
   endtask

   initial begin
      reset     = 1'b0;
      src_valid = '0;
      src_flit  = '0;
      out_ready = 1'b0;
      test_reset();
      test_single_packet();
      test_contention();
      test_backpressure();
      test_drop();
      test_reset_mid_packet();
      test_fairness();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
